// File: rtl/out_port_tx_pkg.sv
// Shared types and constants for the OUT-port UART transmitter.
// State encodings are fixed so the FSM state can be inspected on a bus or in a debugger.
package out_port_tx_pkg;

    localparam int unsigned NBITS   = 8;
    localparam int unsigned STATE_W = 3;
    localparam int unsigned IDX_W   = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // Even parity bit that makes the total count of ones over data+parity even
    function automatic logic even_parity(input logic [NBITS-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/out_port_tx_if.sv
// CPU-side handshake of the output port: OUT strobe and data in, ready/status flags out.
interface out_port_tx_if #(
    parameter int unsigned D = 16
);
    logic         wr;
    logic [D-1:0] wdata;
    logic         ovr_clr;
    logic         fgo;
    logic         busy;
    logic         ovr;

    modport master (output wr, wdata, ovr_clr, input  fgo, busy, ovr);
    modport slave  (input  wr, wdata, ovr_clr, output fgo, busy, ovr);
endinterface

// File: rtl/out_port_tx_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, tick_c marks the last cycle of a bit.
// restart_i forces the count back to 0 so every state starts on a fresh bit boundary.
module baud_gen #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic reset,
    input  logic restart_i,
    output logic tick_c
);
    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick_c = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (restart_i || tick_c) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/out_port_tx.sv
// OUT-path output device: latches wdata[7:0] on an accepted write and sends it as a UART frame.
// Optional even parity bit with OUT_PORT_PARITY_EN defined.
module out_port_tx
    import out_port_tx_pkg::*;
#(
    parameter int unsigned D            = 16,
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic          clk,
    input  logic          reset,
    out_port_tx_if.slave  bus,
    output logic          txd
);
    tx_state_e        state_q, state_d;
    logic [NBITS-1:0] outr_q, outr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             txd_q, txd_d;
    logic             fgo_q, fgo_d;
    logic             busy_q, busy_d;
    logic             ovr_q, ovr_d;
    logic             tick_c;
    logic             restart_c;
    logic             unused_wdata_hi;

    assign unused_wdata_hi = ^bus.wdata[D-1:NBITS];

    baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk       (clk),
        .reset     (reset),
        .restart_i (restart_c),
        .tick_c    (tick_c)
    );

    // Hold the counter at 0 while idle and reload it on every state change
    assign restart_c = (state_q == ST_IDLE) || (state_d != state_q);

    always_comb begin
        state_d = state_q;
        outr_d  = outr_q;
        idx_d   = idx_q;
        txd_d   = txd_q;
        fgo_d   = fgo_q;
        ovr_d   = ovr_q;

        // A write while not ready is dropped; its set beats a same-cycle clear
        if (bus.ovr_clr)         ovr_d = 1'b0;
        if (bus.wr && !fgo_q)    ovr_d = 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.wr && fgo_q) begin
                    outr_d  = bus.wdata[NBITS-1:0];
                    idx_d   = '0;
                    txd_d   = 1'b0;
                    fgo_d   = 1'b0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (tick_c) begin
                    txd_d   = outr_q[0];
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick_c) begin
                    if (idx_q == IDX_W'(NBITS - 1)) begin
`ifdef OUT_PORT_PARITY_EN
                        txd_d   = even_parity(outr_q);
                        state_d = ST_PARITY;
`else
                        txd_d   = 1'b1;
                        state_d = ST_STOP;
`endif
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                        txd_d = outr_q[idx_q + IDX_W'(1)];
                    end
                end
            end
`ifdef OUT_PORT_PARITY_EN
            ST_PARITY: begin
                if (tick_c) begin
                    txd_d   = 1'b1;
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (tick_c) begin
                    fgo_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                txd_d   = 1'b1;
                fgo_d   = 1'b1;
                state_d = ST_IDLE;
            end
        endcase

        busy_d = ~fgo_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            outr_q  <= '0;
            idx_q   <= '0;
            txd_q   <= 1'b1;
            fgo_q   <= 1'b1;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            outr_q  <= outr_d;
            idx_q   <= idx_d;
            txd_q   <= txd_d;
            fgo_q   <= fgo_d;
            busy_q  <= busy_d;
            ovr_q   <= ovr_d;
        end
    end

    assign txd      = txd_q;
    assign bus.fgo  = fgo_q;
    assign bus.busy = busy_q;
    assign bus.ovr  = ovr_q;
endmodule

// File: tb/tb_out_port_tx.sv
// Bench for out_port_tx with CLKS_PER_BIT=4: directed frames plus a randomized write stream
// checked against a frame-level model and a serial-line decoder.
module tb_out_port_tx;

    localparam int CPB = 4;
`ifdef OUT_PORT_PARITY_EN
    localparam bit PAR_EN     = 1'b1;
    localparam int FRAME_BITS = 11;
`else
    localparam bit PAR_EN     = 1'b0;
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYC = FRAME_BITS * CPB;

    logic clk;
    logic reset;
    logic txd;

    out_port_tx_if #(.D(16)) bus ();

    out_port_tx #(.D(16), .CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .txd   (txd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_asserts = 0;
    int n_fail    = 0;

    logic [9:0] exp_q[$];
    logic [9:0] mon_q[$];

    // Serial-line decoder: samples each bit in its middle and records {stop, parity, data}
    logic [7:0] mon_b;
    logic       mon_p;
    logic       mon_s;
    always begin
        @(negedge txd);
        repeat (CPB / 2) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(posedge clk);
            #1 mon_b[i] = txd;
        end
        mon_p = 1'b0;
        if (PAR_EN) begin
            repeat (CPB) @(posedge clk);
            #1 mon_p = txd;
        end
        repeat (CPB) @(posedge clk);
        #1 mon_s = txd;
        mon_q.push_back({mon_s, mon_p, mon_b});
    end

    // Line level expected during bit slot j of a frame carrying b
    function automatic logic model_bit(input logic [7:0] b, input int j);
        if (j == 0)              return 1'b0;
        if (j <= 8)              return b[j-1];
        if (j == FRAME_BITS - 1) return 1'b1;
        return ^b;
    endfunction

    function automatic logic [9:0] model_word(input logic [7:0] b);
        return {1'b1, (PAR_EN ? ^b : 1'b0), b};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Send one word from idle, check every line cycle; optionally attempt a write at cycle drop_at
    task automatic run_frame(input logic [15:0] w, input int drop_at, input bit clr_too);
        chk("fgo_pre", 32'(bus.fgo), 32'd1);
        bus.wr = 1'b1;
        bus.wdata = w;
        step();
        bus.wr = 1'b0;
        exp_q.push_back(model_word(w[7:0]));
        for (int k = 0; k < FRAME_CYC; k++) begin
            chk("txd_bit", 32'(txd), 32'(model_bit(w[7:0], k / CPB)));
            chk("fgo_busy_frame", 32'({bus.fgo, bus.busy}), 32'(2'b01));
            bus.wr      = (k == drop_at);
            bus.ovr_clr = clr_too && (k == drop_at);
            bus.wdata   = 16'($urandom);
            step();
        end
        bus.wr      = 1'b0;
        bus.ovr_clr = 1'b0;
        chk("fgo_busy_end", 32'({bus.fgo, bus.busy}), 32'(2'b10));
        if (drop_at >= 0) chk("ovr_set", 32'(bus.ovr), 32'd1);
    endtask

    task automatic clear_ovr();
        bus.ovr_clr = 1'b1;
        step();
        bus.ovr_clr = 1'b0;
        chk("ovr_clr", 32'(bus.ovr), 32'd0);
    endtask

    task automatic write_when_ready(input logic [7:0] b);
        int t = 0;
        while (!bus.fgo && t < 200) begin
            step();
            t++;
        end
        chk("fgo_wait", 32'(bus.fgo), 32'd1);
        bus.wr = 1'b1;
        bus.wdata = {8'h00, b};
        step();
        bus.wr = 1'b0;
        exp_q.push_back(model_word(b));
        chk("accept_fgo", 32'(bus.fgo), 32'd0);
    endtask

    logic [7:0] b2b [4];
    int         rem;
    logic       ovr_m;
    logic       wr_r;
    logic       clr_r;
    logic [15:0] wd_r;
    int         n_cmp;

    initial begin
        b2b = '{8'h00, 8'hFF, 8'h55, 8'h80};
        reset = 1'b0;
        bus.wr = 1'b0;
        bus.wdata = '0;
        bus.ovr_clr = 1'b0;

        // Reset values
        repeat (3) step();
        chk("rst_txd",  32'(txd),      32'd1);
        chk("rst_fgo",  32'(bus.fgo),  32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_ovr",  32'(bus.ovr),  32'd0);
        reset = 1'b1;
        step();
        chk("idle_txd", 32'(txd), 32'd1);

        // Basic frame
        run_frame(16'h12A5, -1, 1'b0);

        // Overrun mid-frame, then clear
        run_frame(16'h003C, 10, 1'b0);
        clear_ovr();

        // Dropped write and clear in the same cycle: set wins
        run_frame(16'hC3C3, 5, 1'b1);
        clear_ovr();

        // Write on the final stop edge is dropped; next-cycle write is taken immediately
        run_frame(16'h5A01, FRAME_CYC - 1, 1'b0);
        run_frame(16'h0081, -1, 1'b0);
        chk("ovr_after_boundary", 32'(bus.ovr), 32'd1);
        clear_ovr();

        // Parity-sensitive bytes
        run_frame(16'h00A5, -1, 1'b0);
        run_frame(16'h00A4, -1, 1'b0);

        // Back-to-back writes gated on ready
        foreach (b2b[i]) write_when_ready(b2b[i]);
        repeat (FRAME_CYC + 2) step();
        chk("pre_rand_ovr", 32'(bus.ovr), 32'd0);

        // Random write/clear stream against a cycle-count model of the ready window
        rem = 0;
        ovr_m = 1'b0;
        for (int c = 0; c < 600; c++) begin
            wr_r  = ($urandom_range(0, 7) == 0);
            clr_r = ($urandom_range(0, 49) == 0);
            wd_r  = 16'($urandom);
            bus.wr = wr_r;
            bus.ovr_clr = clr_r;
            bus.wdata = wd_r;
            if (clr_r) ovr_m = 1'b0;
            if (rem > 0) begin
                if (wr_r) ovr_m = 1'b1;
                rem--;
            end else if (wr_r) begin
                rem = FRAME_CYC;
                exp_q.push_back(model_word(wd_r[7:0]));
            end
            step();
            chk("rand_fgo_busy", 32'({bus.fgo, bus.busy}), (rem == 0) ? 32'(2'b10) : 32'(2'b01));
            chk("rand_ovr", 32'(bus.ovr), 32'(ovr_m));
        end
        bus.wr = 1'b0;
        bus.ovr_clr = 1'b0;
        repeat (FRAME_CYC + 4) step();

        // Everything the decoder saw, in order
        chk("mon_count", 32'(mon_q.size()), 32'(exp_q.size()));
        n_cmp = (mon_q.size() < exp_q.size()) ? mon_q.size() : exp_q.size();
        for (int i = 0; i < n_cmp; i++) chk("mon_frame", 32'(mon_q[i]), 32'(exp_q[i]));

        // Reset during a start bit returns the line high without a clock edge
        bus.wr = 1'b1;
        bus.wdata = 16'h00F0;
        step();
        bus.wr = 1'b0;
        step();
        chk("abort_pre_txd", 32'(txd), 32'd0);
        #2 reset = 1'b0;
        #1;
        chk("abort_txd",  32'(txd),     32'd1);
        chk("abort_fgo",  32'(bus.fgo), 32'd1);
        chk("abort_ovr",  32'(bus.ovr), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
